// File: rtl/dp_split_seq.sv
// dp_split_seq: walks split indices for dp_core, kicking NTT then madd per
// split, with per-phase watchdog, abort, sticky error and job-done pulse.
// Ports: clk, rst_n (sync, active-low); i_start/i_num_split/i_abort job ctl;
// o_ntt_start/i_ntt_done and o_madd_start/i_madd_done dp_core handshakes;
// o_idx_split split index; o_busy, o_done, o_err, o_err_code status.
module dp_split_seq #(
  parameter int NUM_SPLIT      = 4,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [2:0] i_num_split,
  input  logic       i_abort,
  output logic       o_ntt_start,
  input  logic       i_ntt_done,
  output logic       o_madd_start,
  input  logic       i_madd_done,
  output logic [1:0] o_idx_split,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  typedef enum logic [2:0] {
    IDLE,
    NTT_KICK,
    NTT_WAIT,
    MADD_KICK,
    MADD_WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [2:0] MAX_SPLIT = 3'(NUM_SPLIT);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIM =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [2:0]               nsplit_q, nsplit_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;
  logic                     ntt_done_q;
  logic                     madd_done_q;

  logic                     ntt_rise;
  logic                     madd_rise;
  logic                     cfg_ok;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic [1:0]               idx_last;

  assign ntt_rise  = i_ntt_done & ~ntt_done_q;
  assign madd_rise = i_madd_done & ~madd_done_q;
  assign cfg_ok    = (i_num_split != 3'd0) &&
                     (i_num_split <= MAX_SPLIT);
  assign wd_inc    = wd_q + 1'b1;
  assign idx_last  = 2'(nsplit_q - 3'd1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nsplit_d = nsplit_q;
    wd_d     = wd_q;
    err_d    = err_q;
    code_d   = code_q;
    unique case (state_q)
      IDLE, ERR: begin
        if (i_start) begin
          if (cfg_ok) begin
            nsplit_d = i_num_split;
            idx_d    = 2'd0;
            err_d    = 1'b0;
            code_d   = 2'd0;
            state_d  = NTT_KICK;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = ERR;
          end
        end
      end
      NTT_KICK: begin
        wd_d    = '0;
        state_d = NTT_WAIT;
      end
      NTT_WAIT: begin
        // A rise on the terminal cycle still counts as completion.
        if (ntt_rise) begin
          state_d = MADD_KICK;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TO_LIM) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = ERR;
          end
        end
      end
      MADD_KICK: begin
        wd_d    = '0;
        state_d = MADD_WAIT;
      end
      MADD_WAIT: begin
        if (madd_rise) begin
          if (idx_q == idx_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = NTT_KICK;
          end
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TO_LIM) begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = ERR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (i_abort) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      wd_d    = '0;
      err_d   = 1'b0;
      code_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      nsplit_q    <= 3'd0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
      ntt_done_q  <= 1'b0;
      madd_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nsplit_q    <= nsplit_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      code_q      <= code_d;
      ntt_done_q  <= i_ntt_done;
      madd_done_q <= i_madd_done;
    end
  end

  assign o_ntt_start  = (state_q == NTT_KICK);
  assign o_madd_start = (state_q == MADD_KICK);
  assign o_done       = (state_q == DONE);
  assign o_busy       = (state_q != IDLE) && (state_q != ERR);
  assign o_idx_split  = idx_q;
  assign o_err        = err_q;
  assign o_err_code   = code_q;

endmodule

// File: tb/tb_dp_split_seq.sv
// tb_dp_split_seq: directed bench for dp_split_seq.
// Runs with TIMEOUT_CYCLES=64 so watchdog cases stay short.
module tb_dp_split_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [2:0] i_num_split;
  logic       i_abort;
  logic       o_ntt_start;
  logic       i_ntt_done;
  logic       o_madd_start;
  logic       i_madd_done;
  logic [1:0] o_idx_split;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;

  int checks = 0;
  int errors = 0;
  int ntt_cnt = 0;
  int madd_cnt = 0;
  int done_cnt = 0;
  int idx_max = 0;
  logic [1:0] ntt_idx [8];

  dp_split_seq #(
    .NUM_SPLIT(4),
    .TIMEOUT_WIDTH(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_num_split(i_num_split),
    .i_abort(i_abort),
    .o_ntt_start(o_ntt_start),
    .i_ntt_done(i_ntt_done),
    .o_madd_start(o_madd_start),
    .i_madd_done(i_madd_done),
    .o_idx_split(o_idx_split),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_ntt_start) begin
      if (ntt_cnt < 8) ntt_idx[ntt_cnt] = o_idx_split;
      ntt_cnt++;
    end
    if (o_madd_start) madd_cnt++;
    if (o_done) done_cnt++;
    if (o_busy && int'(o_idx_split) > idx_max)
      idx_max = int'(o_idx_split);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    ntt_cnt = 0;
    madd_cnt = 0;
    done_cnt = 0;
    idx_max = 0;
  endtask

  task automatic start_job(input logic [2:0] n);
    i_num_split = n;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  // Entered just after a kick for split s is visible.
  task automatic do_split(input int s, input int last, input bit stale);
    if (stale) begin
      tick(2);
      i_ntt_done = 1'b0;
      tick(5);
      checks++;
      if (madd_cnt !== s) begin
        errors++;
        $display("FAIL stale_ignored: madd_cnt %0d exp %0d", madd_cnt, s);
      end
    end else begin
      i_ntt_done = 1'b0;
      tick(3);
    end
    i_ntt_done = 1'b1;
    tick(1);
    checks++;
    if (o_madd_start !== 1'b1 || o_idx_split !== 2'(s)) begin
      errors++;
      $display("FAIL madd_kick%0d: start %0b idx %0d exp 1 %0d",
               s, o_madd_start, o_idx_split, s);
    end
    i_ntt_done = 1'b0;
    tick(4);
    i_madd_done = 1'b1;
    tick(1);
    i_madd_done = 1'b0;
    checks++;
    if (s == last) begin
      if (o_done !== 1'b1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse: done %0b busy %0b exp 1 1",
                 o_done, o_busy);
      end
    end else begin
      if (o_ntt_start !== 1'b1 || o_idx_split !== 2'(s + 1)) begin
        errors++;
        $display("FAIL ntt_kick%0d: start %0b idx %0d exp 1 %0d",
                 s + 1, o_ntt_start, o_idx_split, s + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({o_ntt_start, o_madd_start, o_busy, o_done, o_err} !== 5'b0 ||
        o_idx_split !== 2'd0 || o_err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_outs: ntt %0b madd %0b busy %0b done %0b err %0b idx %0d code %0d exp all 0",
               o_ntt_start, o_madd_start, o_busy, o_done, o_err,
               o_idx_split, o_err_code);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (o_busy !== 1'b0 || o_ntt_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %0b ntt %0b exp 0 0",
               o_busy, o_ntt_start);
    end
  endtask

  task automatic test_single();
    clr_cnt();
    start_job(3'd1);
    checks++;
    if (o_ntt_start !== 1'b1 || o_busy !== 1'b1 || o_idx_split !== 2'd0) begin
      errors++;
      $display("FAIL single_kick: ntt %0b busy %0b idx %0d exp 1 1 0",
               o_ntt_start, o_busy, o_idx_split);
    end
    tick(9);
    i_ntt_done = 1'b1;
    tick(1);
    i_ntt_done = 1'b0;
    checks++;
    if (o_madd_start !== 1'b1) begin
      errors++;
      $display("FAIL single_madd: got %0b exp 1", o_madd_start);
    end
    tick(19);
    i_madd_done = 1'b1;
    tick(1);
    i_madd_done = 1'b0;
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got %0b exp 1", o_done);
    end
    tick(1);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy %0b done %0b exp 0 0", o_busy, o_done);
    end
    checks++;
    if (ntt_cnt != 1 || madd_cnt != 1 || done_cnt != 1 || idx_max != 0) begin
      errors++;
      $display("FAIL single_counts: ntt %0d madd %0d done %0d idxmax %0d exp 1 1 1 0",
               ntt_cnt, madd_cnt, done_cnt, idx_max);
    end
  endtask

  task automatic test_four_stale();
    i_ntt_done = 1'b1;
    tick(2);
    clr_cnt();
    start_job(3'd4);
    checks++;
    if (o_ntt_start !== 1'b1) begin
      errors++;
      $display("FAIL four_kick: got %0b exp 1", o_ntt_start);
    end
    do_split(0, 3, 1'b1);
    for (int s = 1; s < 4; s++) do_split(s, 3, 1'b0);
    tick(1);
    checks++;
    if (ntt_cnt != 4 || madd_cnt != 4 || done_cnt != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL four_counts: ntt %0d madd %0d done %0d busy %0b exp 4 4 1 0",
               ntt_cnt, madd_cnt, done_cnt, o_busy);
    end
    checks++;
    if (ntt_idx[0] !== 2'd0 || ntt_idx[1] !== 2'd1 ||
        ntt_idx[2] !== 2'd2 || ntt_idx[3] !== 2'd3) begin
      errors++;
      $display("FAIL four_idx_seq: %0d %0d %0d %0d exp 0 1 2 3",
               ntt_idx[0], ntt_idx[1], ntt_idx[2], ntt_idx[3]);
    end
  endtask

  task automatic test_rise_on_terminal();
    start_job(3'd1);
    tick(64);
    i_ntt_done = 1'b1;
    tick(1);
    i_ntt_done = 1'b0;
    checks++;
    if (o_madd_start !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL rise_terminal: madd %0b err %0b exp 1 0",
               o_madd_start, o_err);
    end
    tick(3);
    i_madd_done = 1'b1;
    tick(1);
    i_madd_done = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL rise_terminal_done: done %0b err %0b exp 1 0",
               o_done, o_err);
    end
    tick(1);
  endtask

  task automatic test_timeout();
    int n;
    start_job(3'd3);
    do_split(0, 2, 1'b0);
    do_split(1, 2, 1'b0);
    i_ntt_done = 1'b0;
    tick(3);
    i_ntt_done = 1'b1;
    tick(1);
    i_ntt_done = 1'b0;
    checks++;
    if (o_madd_start !== 1'b1 || o_idx_split !== 2'd2) begin
      errors++;
      $display("FAIL to_kick: madd %0b idx %0d exp 1 2",
               o_madd_start, o_idx_split);
    end
    n = 0;
    while (o_err !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (n - 1 != 64) begin
      errors++;
      $display("FAIL to_wait_cycles: got %0d exp 64", n - 1);
    end
    checks++;
    if (o_err !== 1'b1 || o_err_code !== 2'd2 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_err: err %0b code %0d busy %0b exp 1 2 0",
               o_err, o_err_code, o_busy);
    end
    tick(2);
    start_job(3'd2);
    checks++;
    if (o_err !== 1'b0 || o_err_code !== 2'd0 ||
        o_ntt_start !== 1'b1 || o_idx_split !== 2'd0) begin
      errors++;
      $display("FAIL to_restart: err %0b code %0d ntt %0b idx %0d exp 0 0 1 0",
               o_err, o_err_code, o_ntt_start, o_idx_split);
    end
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
  endtask

  task automatic test_bad_config();
    clr_cnt();
    start_job(3'd0);
    checks++;
    if (o_err !== 1'b1 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL bad0: err %0b code %0d busy %0b exp 1 3 0",
               o_err, o_err_code, o_busy);
    end
    tick(2);
    start_job(3'd5);
    checks++;
    if (o_err !== 1'b1 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL bad5: err %0b code %0d busy %0b exp 1 3 0",
               o_err, o_err_code, o_busy);
    end
    tick(2);
    checks++;
    if (ntt_cnt != 0 || madd_cnt != 0) begin
      errors++;
      $display("FAIL bad_pulses: ntt %0d madd %0d exp 0 0", ntt_cnt, madd_cnt);
    end
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    checks++;
    if (o_err !== 1'b0 || o_err_code !== 2'd0) begin
      errors++;
      $display("FAIL bad_abort_clear: err %0b code %0d exp 0 0",
               o_err, o_err_code);
    end
  endtask

  task automatic test_abort_collision();
    int n0;
    clr_cnt();
    start_job(3'd2);
    i_ntt_done = 1'b0;
    tick(2);
    i_ntt_done = 1'b1;
    tick(1);
    i_ntt_done = 1'b0;
    tick(3);
    i_abort = 1'b1;
    i_start = 1'b1;
    i_num_split = 3'd2;
    tick(1);
    i_abort = 1'b0;
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_ntt_start !== 1'b0 ||
        o_done !== 1'b0 || o_idx_split !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: busy %0b ntt %0b done %0b idx %0d exp 0 0 0 0",
               o_busy, o_ntt_start, o_done, o_idx_split);
    end
    n0 = ntt_cnt;
    i_madd_done = 1'b1;
    tick(3);
    i_madd_done = 1'b0;
    checks++;
    if (ntt_cnt != n0 || done_cnt != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: ntt %0d done %0d busy %0b exp %0d 0 0",
               ntt_cnt, done_cnt, o_busy, n0);
    end
  endtask

  task automatic test_reset_mid_job();
    int m;
    start_job(3'd2);
    do_split(0, 1, 1'b0);
    tick(2);
    checks++;
    if (o_idx_split !== 2'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: idx %0d busy %0b exp 1 1", o_idx_split, o_busy);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checks++;
    if ({o_ntt_start, o_madd_start, o_busy, o_done, o_err} !== 5'b0 ||
        o_idx_split !== 2'd0 || o_err_code !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: busy %0b idx %0d err %0b exp 0 0 0",
               o_busy, o_idx_split, o_err);
    end
    m = madd_cnt;
    i_ntt_done = 1'b1;
    tick(3);
    i_ntt_done = 1'b0;
    checks++;
    if (madd_cnt != m || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_pulse: madd %0d busy %0b exp %0d 0",
               madd_cnt, o_busy, m);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_num_split = 3'd0;
    i_abort = 1'b0;
    i_ntt_done = 1'b0;
    i_madd_done = 1'b0;
    test_reset();
    test_single();
    test_four_stale();
    test_rise_on_terminal();
    test_timeout();
    test_bad_config();
    test_abort_collision();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
